// File: rtl/output_memory_writer_if.sv
// rtl/output_memory_writer_if.sv - address, result and memory-write channels of the output memory writer
interface output_memory_writer_if #(
    parameter int DATA_WIDTH                   = 8,
    parameter int N                            = 4,
    parameter int RESULT_WIDTH                 = 32,
    parameter int MAX_MATRIX_LENGTH            = 4096,
    parameter int LENGTH_BITS                  = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4
);
    logic                                              address_valid;
    logic                                              address_ready;
    logic [MEMORY_ADDRESS_BITS-1:0]                    address_input;
    logic [LENGTH_BITS-1:0]                            length_input;
    logic                                              result_valid;
    logic                                              result_ready;
    logic [N-1:0][N-1:0][RESULT_WIDTH-1:0]             result_data;
    logic                                              memory_write_valid;
    logic                                              memory_write_ready;
    logic [MEMORY_ADDRESS_BITS-1:0]                    memory_write_address;
    logic [PARALLEL_DATA_STREAMING_SIZE-1:0][DATA_WIDTH-1:0] memory_write_data;

    modport master (
        output address_valid, address_input, length_input,
        output result_valid, result_data,
        output memory_write_ready,
        input  address_ready, result_ready,
        input  memory_write_valid, memory_write_address, memory_write_data
    );

    modport slave (
        input  address_valid, address_input, length_input,
        input  result_valid, result_data,
        input  memory_write_ready,
        output address_ready, result_ready,
        output memory_write_valid, memory_write_address, memory_write_data
    );
endinterface

// File: rtl/output_memory_writer.sv
// rtl/output_memory_writer.sv - streams one NxN result tile row-major into C memory, P elements per beat
// Optional OUTPUT_WRITER_SATURATE_EN: clamp results to the signed DATA_WIDTH range instead of truncating.
module output_memory_writer #(
    parameter int DATA_WIDTH                   = 8,
    parameter int N                            = 4,
    parameter int RESULT_WIDTH                 = 32,
    parameter int MAX_MATRIX_LENGTH            = 4096,
    parameter int LENGTH_BITS                  = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output_memory_writer_if.slave   bus,
    output logic                    busy
);
    localparam int P          = PARALLEL_DATA_STREAMING_SIZE;
    localparam int CHUNKS     = N / P;
    localparam int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int ROW_BITS   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CHUNK_BITS-1:0] CHUNK_LAST = CHUNK_BITS'(CHUNKS - 1);
    localparam logic [ROW_BITS-1:0]   ROW_LAST   = ROW_BITS'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RESULT,
        S_WRITE
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next_state;
    logic [N-1:0][N-1:0][RESULT_WIDTH-1:0]   r_tile;
    logic [MEMORY_ADDRESS_BITS-1:0]          r_base;
    logic [LENGTH_BITS-1:0]                  r_stride;
    logic [ROW_BITS-1:0]                     r_row;
    logic [CHUNK_BITS-1:0]                   r_chunk;
    logic [MEMORY_ADDRESS_BITS-1:0]          r_row_addr;

    logic                                    w_addr_hs;
    logic                                    w_result_hs;
    logic                                    w_write_hs;
    logic                                    w_last_beat;
    logic [MEMORY_ADDRESS_BITS-1:0]          w_addr;
    logic [P-1:0][DATA_WIDTH-1:0]            w_lane;

    function automatic logic [DATA_WIDTH-1:0] convert(input logic signed [RESULT_WIDTH-1:0] value);
`ifdef OUTPUT_WRITER_SATURATE_EN
        localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
            {{(RESULT_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
        localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
        if (value > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end
        if (value < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end
        return value[DATA_WIDTH-1:0];
`else
        return value[DATA_WIDTH-1:0];
`endif
    endfunction

    assign w_addr_hs   = (r_state == S_IDLE) && bus.address_valid;
    assign w_result_hs = (r_state == S_WAIT_RESULT) && bus.result_valid;
    assign w_write_hs  = (r_state == S_WRITE) && bus.memory_write_ready;
    assign w_last_beat = (r_row == ROW_LAST) && (r_chunk == CHUNK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state           = r_state;
        bus.address_ready      = 1'b0;
        bus.result_ready       = 1'b0;
        bus.memory_write_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.address_ready = 1'b1;
                if (bus.address_valid) begin
                    w_next_state = S_WAIT_RESULT;
                end
            end
            S_WAIT_RESULT: begin
                bus.result_ready = 1'b1;
                if (bus.result_valid) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.memory_write_valid = 1'b1;
                if (bus.memory_write_ready && w_last_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Row address advances by accumulation so no stride multiplier is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tile     <= '0;
            r_base     <= '0;
            r_stride   <= '0;
            r_row      <= '0;
            r_chunk    <= '0;
            r_row_addr <= '0;
        end else begin
            if (w_addr_hs) begin
                r_base   <= bus.address_input;
                r_stride <= bus.length_input;
            end
            if (w_result_hs) begin
                r_tile     <= bus.result_data;
                r_row      <= '0;
                r_chunk    <= '0;
                r_row_addr <= r_base;
            end
            if (w_write_hs) begin
                if (r_chunk == CHUNK_LAST) begin
                    r_chunk    <= '0;
                    r_row      <= r_row + 1'b1;
                    r_row_addr <= r_row_addr + MEMORY_ADDRESS_BITS'(r_stride);
                end else begin
                    r_chunk <= r_chunk + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        logic [ROW_BITS-1:0] w_col;
        assign w_col     = ROW_BITS'(int'(r_chunk) * P + k);
        assign w_lane[k] = convert(r_tile[r_row][w_col]);
    end

    assign w_addr = r_row_addr + MEMORY_ADDRESS_BITS'(r_chunk) * MEMORY_ADDRESS_BITS'(P);

    // Outside WRITE the bus is held at zero so idle and reset look identical downstream.
    assign bus.memory_write_address = (r_state == S_WRITE) ? w_addr : '0;
    assign bus.memory_write_data    = (r_state == S_WRITE) ? w_lane : '0;
    assign busy                     = (r_state != S_IDLE);
endmodule
